// File: rtl/arb_write_buffer_pkg.sv
// Shared LC-3b memory-side types for the arbiter write buffer:
// word/line types, line address and the buffer FSM states.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_cache_line;
  typedef logic [11:0]  lc3b_line_addr;

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    READ_L2,
    DRAIN
  } wb_state_t;

  function automatic lc3b_line_addr line_of(lc3b_word a);
    return a[15:4];
  endfunction

endpackage

// File: rtl/arb_write_buffer_if.sv
// Memory request/response bundle between arbiter, write buffer
// and L2. The requester side uses master, the responder slave.
interface arb_write_buffer_if;
  import lc3b_types::*;

  lc3b_word       mem_address;
  logic           mem_read;
  logic           mem_write;
  lc3b_cache_line mem_wdata;
  lc3b_cache_line mem_rdata;
  logic           mem_resp;

  modport master (
    output mem_address,
    output mem_read,
    output mem_write,
    output mem_wdata,
    input  mem_rdata,
    input  mem_resp
  );

  modport slave (
    input  mem_address,
    input  mem_read,
    input  mem_write,
    input  mem_wdata,
    output mem_rdata,
    output mem_resp
  );

endinterface

// File: rtl/arb_write_buffer_wb_fifo.sv
// wb_fifo: DEPTH-entry write-back line store with head/tail/count
// and a per-entry line match vector for merging and lookups.
module wb_fifo
  import lc3b_types::*;
#(
  parameter  int DEPTH = 4,
  localparam int IW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic             pop,
  input  lc3b_line_addr    req_line,
  input  lc3b_cache_line   wdata,
  output logic [DEPTH-1:0] match,
  output lc3b_cache_line   hit_data,
  output lc3b_line_addr    head_line,
  output lc3b_cache_line   head_data,
  output logic             full,
  output logic             empty
);

  localparam logic [IW:0] FULL_CNT = (IW+1)'(DEPTH);

  logic [IW:0]      count;
  logic [IW-1:0]    head;
  logic [IW-1:0]    tail;
  logic [IW-1:0]    hit_idx;
  logic [DEPTH-1:0] valid;
  logic             hit;
  logic             push;
  logic             ovw;
  logic             do_pop;

  lc3b_line_addr  lines [DEPTH];
  lc3b_cache_line data  [DEPTH];

  always_comb begin
    match = '0;
    for (int i = 0; i < DEPTH; i++)
      match[i] = valid[i] && (lines[i] == req_line);
  end

  always_comb begin
    hit_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--)
      if (match[i]) hit_idx = IW'(i);
  end

  assign hit       = |match;
  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign push      = wr_en && !hit && !full;
  assign ovw       = wr_en && hit;
  assign do_pop    = pop && !empty;
  assign hit_data  = data[hit_idx];
  assign head_line = lines[head];
  assign head_data = data[head];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        valid[tail] <= 1'b1;
        tail        <= tail + IW'(1);
      end
      if (do_pop) begin
        valid[head] <= 1'b0;
        head        <= head + IW'(1);
      end
      unique case ({push, do_pop})
        2'b10:   count <= count + (IW+1)'(1);
        2'b01:   count <= count - (IW+1)'(1);
        default: ;
      endcase
    end
  end

  // Payload needs no reset: valid bits gate every use of it.
  always_ff @(posedge clk) begin
    if (push) begin
      lines[tail] <= req_line;
      data[tail]  <= wdata;
    end else if (ovw) begin
      data[hit_idx] <= wdata;
    end
  end

endmodule

// File: rtl/arb_write_buffer.sv
// Write buffer between L2 arbiter and L2: merges write-backs by line,
// drains them when idle. WB_READ_FORWARD_EN enables read forwarding.
module arb_write_buffer
  import lc3b_types::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  arb_write_buffer_if.slave   l2arb,
  arb_write_buffer_if.master  wb
);

`ifdef WB_READ_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  wb_state_t        state;
  logic [DEPTH-1:0] match;
  lc3b_cache_line   hit_data;
  lc3b_line_addr    head_line;
  lc3b_cache_line   head_data;
  logic             full;
  logic             empty;
  logic             hit;
  logic             idle;
  logic             rd_fwd;
  logic             rd_miss;
  logic             wr_ok;
  logic             start_drain;
  logic             pop;

  assign hit     = |match;
  assign idle    = (state == IDLE);
  assign rd_fwd  = idle && l2arb.mem_read && hit && FWD;
  assign rd_miss = idle && l2arb.mem_read && !hit;
  assign wr_ok   = idle && !l2arb.mem_read && l2arb.mem_write
                   && (hit || !full);
  // Stalled reads and writes fall through to draining.
  assign start_drain = idle && !empty && !rd_fwd && !rd_miss && !wr_ok;
  assign pop         = (state == DRAIN) && wb.mem_resp;

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en     (wr_ok),
    .pop       (pop),
    .req_line  (line_of(l2arb.mem_address)),
    .wdata     (l2arb.mem_wdata),
    .match     (match),
    .hit_data  (hit_data),
    .head_line (head_line),
    .head_data (head_data),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      l2arb.mem_rdata <= '0;
      l2arb.mem_resp  <= 1'b0;
      wb.mem_address  <= '0;
      wb.mem_read     <= 1'b0;
      wb.mem_write    <= 1'b0;
      wb.mem_wdata    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            rd_fwd: begin
              l2arb.mem_rdata <= hit_data;
              l2arb.mem_resp  <= 1'b1;
              state           <= ACK;
            end
            rd_miss: begin
              wb.mem_read    <= 1'b1;
              wb.mem_address <= l2arb.mem_address;
              state          <= READ_L2;
            end
            wr_ok: begin
              l2arb.mem_resp <= 1'b1;
              state          <= ACK;
            end
            start_drain: begin
              wb.mem_write   <= 1'b1;
              wb.mem_address <= {head_line, 4'h0};
              wb.mem_wdata   <= head_data;
              state          <= DRAIN;
            end
            default: ;
          endcase
        end
        ACK: begin
          l2arb.mem_resp <= 1'b0;
          state          <= IDLE;
        end
        READ_L2: begin
          if (wb.mem_resp) begin
            wb.mem_read     <= 1'b0;
            l2arb.mem_rdata <= wb.mem_rdata;
            l2arb.mem_resp  <= 1'b1;
            state           <= ACK;
          end
        end
        DRAIN: begin
          if (wb.mem_resp) begin
            wb.mem_write <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
